// File: rtl/ddr_pkg.sv
// ============================================================================
// Module : ddr_pkg
// Brief  : Shared types and sizes for the DDR responder.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package ddr_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WAIT  = 3'd1,
    XFER  = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } ddr_state_e;

  localparam int DDR_BEATS  = 8;
  localparam int DDR_BEAT_W = 64;
  localparam int DDR_LINE_W = 512;
  localparam int DDR_LAT_W  = 8;

  // Bit offset of beat k inside a line.
  function automatic logic [8:0] beat_lsb(input logic [2:0] k);
    return {k, 6'd0};
  endfunction

endpackage

`default_nettype wire

// File: rtl/ddr_word_ram.sv
// ============================================================================
// Module : ddr_word_ram
// Brief  : 1RW synchronous word RAM, 1-cycle read latency, contents not reset.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module ddr_word_ram
  import ddr_pkg::*;
#(
  parameter int AW = 19
) (
  input  logic                  clock,
  input  logic                  ce,
  input  logic                  we,
  input  logic [AW-1:0]         addr,
  input  logic [DDR_BEAT_W-1:0] wdata,
  output logic [DDR_BEAT_W-1:0] rdata
);

  logic [DDR_BEAT_W-1:0] r_mem [2**AW];
  logic [DDR_BEAT_W-1:0] r_rdata;

  always_ff @(posedge clock) begin
    if (ce) begin
      if (we) begin
        r_mem[addr] <= wdata;
      end else begin
        r_rdata <= r_mem[addr];
      end
    end
  end

  assign rdata = r_rdata;

endmodule

`default_nettype wire

// File: rtl/ddr_responder.sv
// ============================================================================
// Module : ddr_responder
// Brief  : Memory end of the DDR channel: serialised line/word read & write.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module ddr_responder
  import ddr_pkg::*;
#(
  parameter int LINE_AW       = 16,
  parameter int READ_LATENCY  = 8,
  parameter int WRITE_LATENCY = 4
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  ddr_chip_enable,
  input  logic [63:0]           ddr_index,
  input  logic                  ddr_write_enable,
  input  logic                  ddr_burst_mode,
  input  logic [DDR_LINE_W-1:0] ddr_write_data,
  output logic [DDR_LINE_W-1:0] ddr_read_data,
  output logic                  ddr_operation_done,
  output logic                  ddr_ready,
  output logic                  ddr_protocol_err
);

  localparam int WORD_AW = LINE_AW + 3;
  localparam logic [DDR_LAT_W-1:0] RD_LAT = DDR_LAT_W'(READ_LATENCY);
  localparam logic [DDR_LAT_W-1:0] WR_LAT = DDR_LAT_W'(WRITE_LATENCY);

  ddr_state_e            r_state;
  ddr_state_e            w_next;

  logic [WORD_AW-1:0]    r_addr;
  logic                  r_we;
  logic                  r_burst;
  logic [DDR_LINE_W-1:0] r_wdata;
  logic [DDR_LAT_W-1:0]  r_lat;
  logic [2:0]            r_beat;
  logic                  r_cap_valid;
  logic [2:0]            r_cap_slot;
  logic [DDR_LINE_W-1:0] r_rdata;
  logic                  r_err;

  logic                  w_accept;
  logic                  w_last_beat;
  logic                  w_lat_done;
  logic                  w_ready;
  logic                  w_done;
  logic                  w_ram_ce;
  logic [WORD_AW-1:0]    w_ram_addr;
  logic [DDR_BEAT_W-1:0] w_ram_wdata;
  logic [DDR_BEAT_W-1:0] w_ram_rdata;
  logic                  w_unused_idx;

  // Address bits outside the modelled capacity and the byte offset are dropped.
  assign w_unused_idx = ^{ddr_index[63:LINE_AW+6], ddr_index[2:0]};

  assign w_accept    = (r_state == IDLE) && ddr_chip_enable;
  assign w_last_beat = r_burst ? (r_beat == 3'd7) : 1'b1;
  assign w_lat_done  = (r_lat == DDR_LAT_W'(1));

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next   = r_state;
    w_ready  = 1'b0;
    w_done   = 1'b0;
    w_ram_ce = 1'b0;
    case (r_state)
      IDLE: begin
        w_ready = 1'b1;
        if (ddr_chip_enable) begin
          w_next = WAIT;
        end
      end
      WAIT: begin
        if (w_lat_done) begin
          w_next = XFER;
        end
      end
      XFER: begin
        w_ram_ce = 1'b1;
        if (w_last_beat) begin
          w_next = DRAIN;
        end
      end
      DRAIN: begin
        w_next = DONE;
      end
      DONE: begin
        w_done = 1'b1;
        w_next = IDLE;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Request latch (datapath only; control state is reset separately)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (w_accept) begin
      r_addr  <= ddr_index[LINE_AW+5:3];
      r_we    <= ddr_write_enable;
      r_burst <= ddr_burst_mode;
      r_wdata <= ddr_write_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Latency and beat counters
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_lat  <= '0;
      r_beat <= '0;
    end else if (w_accept) begin
      r_lat  <= ddr_write_enable ? WR_LAT : RD_LAT;
      r_beat <= '0;
    end else begin
      if (r_state == WAIT) begin
        r_lat <= r_lat - DDR_LAT_W'(1);
      end
      if (r_state == XFER) begin
        r_beat <= r_beat + 3'd1;
      end
    end
  end

  // Burst beats stay inside their own line: the 3-bit beat replaces the low word bits.
  assign w_ram_addr  = r_burst ? {r_addr[WORD_AW-1:3], r_beat} : r_addr;
  assign w_ram_wdata = r_wdata[beat_lsb(r_beat) +: DDR_BEAT_W];

  ddr_word_ram #(
    .AW (WORD_AW)
  ) u_ram (
    .clock (clock),
    .ce    (w_ram_ce),
    .we    (r_we),
    .addr  (w_ram_addr),
    .wdata (w_ram_wdata),
    .rdata (w_ram_rdata)
  );

  // ---------------------------------------------------------------------------
  // Read-data assembly: RAM word arrives one cycle after its beat was issued
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_cap_valid <= 1'b0;
      r_cap_slot  <= '0;
      r_rdata     <= '0;
    end else begin
      r_cap_valid <= (r_state == XFER) && !r_we;
      r_cap_slot  <= r_beat;
      if (r_cap_valid) begin
        if (r_burst) begin
          r_rdata[beat_lsb(r_cap_slot) +: DDR_BEAT_W] <= w_ram_rdata;
        end else begin
          r_rdata <= {{(DDR_LINE_W-DDR_BEAT_W){1'b0}}, w_ram_rdata};
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Protocol checker
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_err <= 1'b0;
    end else if (ddr_chip_enable && (r_state != IDLE)) begin
      r_err <= 1'b1;
    end
  end

  assign ddr_read_data      = r_rdata;
  assign ddr_operation_done = w_done;
  assign ddr_ready          = w_ready;
  assign ddr_protocol_err   = r_err;

  // ---------------------------------------------------------------------------
  // Assertions
  // ---------------------------------------------------------------------------
  a_done_pulse : assert property (@(posedge clock) disable iff (!reset_n)
    ddr_operation_done |=> !ddr_operation_done);

  a_ready_idle : assert property (@(posedge clock)
    ddr_ready == (r_state == IDLE));

  a_lat_range : assert property (@(posedge clock)
    (READ_LATENCY >= 1) && (READ_LATENCY <= 255) &&
    (WRITE_LATENCY >= 1) && (WRITE_LATENCY <= 255));

endmodule

`default_nettype wire

// File: tb/tb_ddr_responder.sv
// ============================================================================
// Module : tb_ddr_responder
// Brief  : Scoreboard bench for ddr_responder with directed vectors.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_ddr_responder;

  localparam int LINE_AW = 16;
  localparam int RL      = 8;
  localparam int WL      = 4;

  logic         clock = 1'b0;
  logic         reset_n;
  logic         ddr_chip_enable;
  logic [63:0]  ddr_index;
  logic         ddr_write_enable;
  logic         ddr_burst_mode;
  logic [511:0] ddr_write_data;
  logic [511:0] ddr_read_data;
  logic         ddr_operation_done;
  logic         ddr_ready;
  logic         ddr_protocol_err;

  always #5 clock = ~clock;

  ddr_responder #(
    .LINE_AW       (LINE_AW),
    .READ_LATENCY  (RL),
    .WRITE_LATENCY (WL)
  ) dut (
    .clock              (clock),
    .reset_n            (reset_n),
    .ddr_chip_enable    (ddr_chip_enable),
    .ddr_index          (ddr_index),
    .ddr_write_enable   (ddr_write_enable),
    .ddr_burst_mode     (ddr_burst_mode),
    .ddr_write_data     (ddr_write_data),
    .ddr_read_data      (ddr_read_data),
    .ddr_operation_done (ddr_operation_done),
    .ddr_ready          (ddr_ready),
    .ddr_protocol_err   (ddr_protocol_err)
  );

  typedef struct {
    int           cyc;
    logic [511:0] rd;
  } exp_t;

  exp_t         sbq[$];
  exp_t         mon_e;
  int           checks   = 0;
  int           failures = 0;
  int           cyc      = 0;
  logic [511:0] last_rd;
  logic [511:0] line_a, line_a2, line_b;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at cycle %0d: actual=%h required=%h", name, cyc, act, exp);
    end
  endtask

  // Monitor: every done pulse is matched against the oldest expected response.
  always @(negedge clock) begin
    if (reset_n) begin
      while (sbq.size() > 0 && sbq[0].cyc < cyc) begin
        checks++;
        failures++;
        $display("FAIL missed_done: no done at cycle %0d (now %0d)", sbq[0].cyc, cyc);
        void'(sbq.pop_front());
      end
      if (ddr_operation_done) begin
        if (sbq.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_done at cycle %0d: actual=1 required=0", cyc);
        end else begin
          mon_e = sbq.pop_front();
          chk("done_cycle", 512'(cyc), 512'(mon_e.cyc));
          chk("read_data_at_done", ddr_read_data, mon_e.rd);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic issue(input logic we, input logic burst, input logic [63:0] idx,
                       input logic [511:0] wd, input logic [511:0] exp_rd);
    exp_t x;
    chk("ready_before_accept", 512'(ddr_ready), 512'(1));
    ddr_chip_enable  = 1'b1;
    ddr_write_enable = we;
    ddr_burst_mode   = burst;
    ddr_index        = idx;
    ddr_write_data   = wd;
    x.cyc = cyc + (we ? WL : RL) + (burst ? 8 : 1) + 2;
    x.rd  = exp_rd;
    sbq.push_back(x);
    tick();
    ddr_chip_enable  = 1'b0;
    ddr_write_enable = ~we;
    ddr_burst_mode   = ~burst;
    ddr_index        = {$urandom, $urandom};
    ddr_write_data   = {16{$urandom}};
  endtask

  task automatic issue_write(input logic burst, input logic [63:0] idx, input logic [511:0] wd);
    issue(1'b1, burst, idx, wd, last_rd);
  endtask

  task automatic issue_read(input logic burst, input logic [63:0] idx, input logic [511:0] exp_rd);
    issue(1'b0, burst, idx, {16{32'hA5A5_5A5A}}, exp_rd);
    last_rd = exp_rd;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!ddr_ready && n < 400) begin
      tick();
      n++;
    end
    if (!ddr_ready) begin
      checks++;
      failures++;
      $display("FAIL ready_timeout at cycle %0d: actual=0 required=1", cyc);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish at time %0t", $time);
    $fatal(1);
  end

  initial begin
    for (int k = 0; k < 8; k++) begin
      line_a[64*k +: 64] = 64'h1111_0000_0000_0000 + 64'(k);
      line_b[64*k +: 64] = 64'hBBBB_0000_0000_0000 + 64'(k);
    end
    line_a2          = line_a;
    line_a2[127:64]  = 64'hDEAD_BEEF_CAFE_F00D;
    last_rd          = '0;

    reset_n          = 1'b0;
    ddr_chip_enable  = 1'b0;
    ddr_index        = '0;
    ddr_write_enable = 1'b0;
    ddr_burst_mode   = 1'b0;
    ddr_write_data   = '0;
    repeat (5) tick();
    reset_n = 1'b1;

    chk("reset_ready", 512'(ddr_ready), 512'(1));
    chk("reset_done", 512'(ddr_operation_done), 512'(0));
    chk("reset_read_data", ddr_read_data, '0);
    chk("reset_protocol_err", 512'(ddr_protocol_err), 512'(0));

    // Burst write accepted at cycle 10, done expected at 24.
    while (cyc < 10) tick();
    issue_write(1'b1, 64'h1000, line_a);
    for (int c = 11; c <= 24; c++) begin
      chk("ready_low_during_write", 512'(ddr_ready), 512'(0));
      tick();
    end
    // Back-to-back burst read in the first ready cycle.
    chk("ready_after_write", 512'(ddr_ready), 512'(1));
    issue_read(1'b1, 64'h1000, line_a);
    wait_ready();
    repeat (3) tick();
    chk("read_data_held", ddr_read_data, line_a);

    // Single write then single read of the same word via a different byte offset.
    issue_write(1'b0, 64'h1008, {448'h0, 64'hDEAD_BEEF_CAFE_F00D});
    wait_ready();
    chk("read_data_kept_by_write", ddr_read_data, line_a);
    issue_read(1'b0, 64'h100C, {448'h0, 64'hDEAD_BEEF_CAFE_F00D});
    wait_ready();
    chk("protocol_err_clear", 512'(ddr_protocol_err), 512'(0));

    // Burst read with an intruding request at T+3.
    issue_read(1'b1, 64'h1000, line_a2);
    tick();
    tick();
    ddr_chip_enable  = 1'b1;
    ddr_index        = 64'h2000;
    ddr_write_enable = 1'b1;
    ddr_burst_mode   = 1'b0;
    tick();
    ddr_chip_enable  = 1'b0;
    chk("protocol_err_set", 512'(ddr_protocol_err), 512'(1));
    wait_ready();
    chk("protocol_err_sticky", 512'(ddr_protocol_err), 512'(1));

    // Burst write aborted by reset during T+2, nothing committed yet.
    issue_write(1'b1, 64'h1000, line_b);
    tick();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    sbq.delete();
    last_rd = '0;
    chk("abort_ready", 512'(ddr_ready), 512'(1));
    chk("abort_done", 512'(ddr_operation_done), 512'(0));
    chk("abort_read_data", ddr_read_data, '0);
    chk("abort_protocol_err", 512'(ddr_protocol_err), 512'(0));

    // Aliased address sees the old line contents.
    issue_read(1'b1, 64'h1000 + (64'd1 << (LINE_AW + 6)), line_a2);
    wait_ready();
    issue_read(1'b0, 64'h1015, {448'h0, 64'h1111_0000_0000_0002});
    wait_ready();
    repeat (4) tick();
    chk("final_read_data_held", ddr_read_data, {448'h0, 64'h1111_0000_0000_0002});
    chk("scoreboard_empty", 512'(sbq.size()), 512'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
